// File: rtl/fakeram7_dp_ctrl_if.sv
// fakeram7_dp_ctrl_if
//   Client-side bundle for the dual-port fakeram7 controller: two request
//   channels (A/B) and two read-response channels (A/B), all valid/ready.
//   master : client logic (drives requests, consumes responses)
//   slave  : controller (accepts requests, produces responses)
`timescale 1ns/1ps
interface fakeram7_dp_ctrl_if #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                  req_valid_a, req_valid_b;
    logic                  req_ready_a, req_ready_b;
    logic                  req_we_a,    req_we_b;
    logic [ADDR_WIDTH-1:0] req_addr_a,  req_addr_b;
    logic [BITS-1:0]       req_wdata_a, req_wdata_b;
    logic [BITS-1:0]       req_wmask_a, req_wmask_b;
    logic                  rsp_valid_a, rsp_valid_b;
    logic                  rsp_ready_a, rsp_ready_b;
    logic [BITS-1:0]       rsp_data_a,  rsp_data_b;

    modport master (
        output req_valid_a, req_valid_b, req_we_a, req_we_b,
               req_addr_a, req_addr_b, req_wdata_a, req_wdata_b,
               req_wmask_a, req_wmask_b, rsp_ready_a, rsp_ready_b,
        input  req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b,
               rsp_data_a, rsp_data_b
    );

    modport slave (
        input  req_valid_a, req_valid_b, req_we_a, req_we_b,
               req_addr_a, req_addr_b, req_wdata_a, req_wdata_b,
               req_wmask_a, req_wmask_b, rsp_ready_a, rsp_ready_b,
        output req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b,
               rsp_data_a, rsp_data_b
    );
endinterface

// File: rtl/fakeram7_dp_ctrl.sv
// fakeram7_dp_ctrl
//   Initiator-side controller for the dual-port 2048x32 fakeram7 macro.
//   Two independent request channels issue straight onto the macro pins in
//   the accept cycle; reads come back one cycle later and land in a small
//   per-port response FIFO guarded by credits so no read is ever dropped.
//   Same-address write/write collisions are arbitrated round-robin.
// Ports:
//   clk, rst_n         clock (shared with macro), async active-low reset
//   bus (slave)        request/response channels A and B
//   ram_addr/we/wd/wmask_a/b, ram_ce   macro input pins
//   ram_rd_a/b         macro read data
// Build option:
//   FAKERAM7_DP_CTRL_CE_GATE_EN  when defined, ram_ce is asserted only in
//   cycles where a port issues; otherwise it is high whenever out of reset.
`timescale 1ns/1ps
module fakeram7_dp_ctrl #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fakeram7_dp_ctrl_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    output logic [BITS-1:0]       ram_wd_a,
    output logic [BITS-1:0]       ram_wd_b,
    output logic [BITS-1:0]       ram_wmask_a,
    output logic [BITS-1:0]       ram_wmask_b,
    output logic                  ram_ce,
    input  logic [BITS-1:0]       ram_rd_a,
    input  logic [BITS-1:0]       ram_rd_b
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]            req_valid, req_we, rsp_ready;
    logic [1:0]            base_ready, req_ready, issue, rsp_valid, ram_we;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [ADDR_WIDTH-1:0] ram_addr [2];
    logic [BITS-1:0]       req_wdata [2];
    logic [BITS-1:0]       req_wmask [2];
    logic [BITS-1:0]       ram_wd [2];
    logic [BITS-1:0]       ram_wmask [2];
    logic [BITS-1:0]       ram_rd [2];
    logic [BITS-1:0]       rsp_data [2];
    logic                  active;
    logic                  rr_pri;
    logic                  collide;

    assign req_valid    = {bus.req_valid_b, bus.req_valid_a};
    assign req_we       = {bus.req_we_b, bus.req_we_a};
    assign rsp_ready    = {bus.rsp_ready_b, bus.rsp_ready_a};
    assign req_addr[0]  = bus.req_addr_a;
    assign req_addr[1]  = bus.req_addr_b;
    assign req_wdata[0] = bus.req_wdata_a;
    assign req_wdata[1] = bus.req_wdata_b;
    assign req_wmask[0] = bus.req_wmask_a;
    assign req_wmask[1] = bus.req_wmask_b;
    assign ram_rd[0]    = ram_rd_a;
    assign ram_rd[1]    = ram_rd_b;

    assign bus.req_ready_a = req_ready[0];
    assign bus.req_ready_b = req_ready[1];
    assign bus.rsp_valid_a = rsp_valid[0];
    assign bus.rsp_valid_b = rsp_valid[1];
    assign bus.rsp_data_a  = rsp_data[0];
    assign bus.rsp_data_b  = rsp_data[1];
    assign ram_addr_a      = ram_addr[0];
    assign ram_addr_b      = ram_addr[1];
    assign ram_we_a        = ram_we[0];
    assign ram_we_b        = ram_we[1];
    assign ram_wd_a        = ram_wd[0];
    assign ram_wd_b        = ram_wd[1];
    assign ram_wmask_a     = ram_wmask[0];
    assign ram_wmask_b     = ram_wmask[1];

    // active goes high one edge after reset release, so nothing is accepted
    // while the macro enable is still low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            rr_pri <= 1'b0;
        end else begin
            active <= 1'b1;
            if (collide)
                rr_pri <= ~rr_pri;
        end
    end

    // Write/write to one address: only the priority port sees ready.
    always_comb begin
        req_ready = base_ready;
        collide   = (&req_valid) & (&req_we) & (req_addr[0] == req_addr[1])
                    & (&base_ready);
        if (collide) begin
            if (rr_pri)
                req_ready[0] = 1'b0;
            else
                req_ready[1] = 1'b0;
        end
    end

    assign issue = req_valid & req_ready;

`ifdef FAKERAM7_DP_CTRL_CE_GATE_EN
    assign ram_ce = |issue;
`else
    assign ram_ce = active;
`endif

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [BITS-1:0]       fifo_mem [RSP_DEPTH];
        logic [PW-1:0]         wr_ptr, rd_ptr;
        logic [CW-1:0]         count;
        logic [CW:0]           occ;
        logic                  inflight, push, pop, rd_ok;
        logic [ADDR_WIDTH-1:0] addr_q;
        logic [BITS-1:0]       wd_q, wmask_q;

        // inflight marks that ram_rd carries this port's read data this cycle
        assign push = inflight;
        assign pop  = rsp_valid[p] & rsp_ready[p];
        assign occ  = {1'b0, count} + {{CW{1'b0}}, inflight};
        // A slot freed by this cycle's pop may be reused by this cycle's read.
        assign rd_ok = (occ < (CW+1)'(RSP_DEPTH)) | pop;
        assign base_ready[p] = active & (req_we[p] | rd_ok);

        assign rsp_valid[p] = (count != '0);
        assign rsp_data[p]  = fifo_mem[rd_ptr];

        // Idle ports hold their last pin values so the macro never sees X.
        assign ram_addr[p]  = issue[p] ? req_addr[p]  : addr_q;
        assign ram_wd[p]    = issue[p] ? req_wdata[p] : wd_q;
        assign ram_wmask[p] = issue[p] ? req_wmask[p] : wmask_q;
        assign ram_we[p]    = issue[p] & req_we[p];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inflight <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                addr_q   <= '0;
                wd_q     <= '0;
                wmask_q  <= '0;
                for (int i = 0; i < RSP_DEPTH; i++)
                    fifo_mem[i] <= '0;
            end else begin
                inflight <= issue[p] & ~req_we[p];
                addr_q   <= ram_addr[p];
                wd_q     <= ram_wd[p];
                wmask_q  <= ram_wmask[p];
                if (push) begin
                    fifo_mem[wr_ptr] <= ram_rd[p];
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: doc/fakeram7_dp_ctrl.md
Name: fakeram7_dp_ctrl

Overview:
- Initiator-side controller that drives the dual-port 2048x32 fakeram7 macro pins: addr_in_A/B, we_in_A/B, wd_in_A/B, w_mask_in_A/B, ce_in. Captures rd_out_A/B.
- Presents two independent valid/ready request channels and two valid/ready read-response channels to client logic.
- Resolves same-address write collisions between the ports with round-robin priority.
- Buffers read data so that backpressure never loses a macro read.

Parameters:
- BITS, 32, data width; must match the macro.
- ADDR_WIDTH, 11, address width; must match the macro.
- RSP_DEPTH, 2, per-port response FIFO depth (>=2, power of two).

Ports:
- clk  in  1  single clock; same clock as the macro clk.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_a / req_valid_b  in  1  request valid, port A / B.
- req_ready_a / req_ready_b  out  1  request accepted when valid&ready.
- req_we_a / req_we_b  in  1  1=write, 0=read.
- req_addr_a / req_addr_b  in  ADDR_WIDTH  word address.
- req_wdata_a / req_wdata_b  in  BITS  write data.
- req_wmask_a / req_wmask_b  in  BITS  per-bit write mask.
- rsp_valid_a / rsp_valid_b  out  1  read data valid.
- rsp_ready_a / rsp_ready_b  in  1  client consumes response.
- rsp_data_a / rsp_data_b  out  BITS  read data.
- ram_addr_a / ram_addr_b  out  ADDR_WIDTH  to macro addr_in_A/B.
- ram_we_a / ram_we_b  out  1  to macro we_in_A/B.
- ram_wd_a / ram_wd_b  out  BITS  to macro wd_in_A/B.
- ram_wmask_a / ram_wmask_b  out  BITS  to macro w_mask_in_A/B.
- ram_ce  out  1  to macro ce_in.
- ram_rd_a / ram_rd_b  in  BITS  from macro rd_out_A/B.

Behaviour:
- Reset (async, rst_n low):
  - ram_we_*=0, ram_addr_*=0, ram_wd_*=0, ram_wmask_*=0, ram_ce=0.
  - FIFOs empty; rsp_valid_*=0, rsp_data_*=0; in-flight flags=0; rr_pri=A; req_ready_*=0.
  - Macro pins are never X after reset, so the macro never corrupts its array.
- Issue:
  - Port accepted in cycle N when valid&ready.
  - ram_* pins are driven combinationally from the accepted request in cycle N.
  - Macro samples the pins at the clk edge ending cycle N.
  - When a port has no accepted request: ram_we_x=0 and ram_addr_x holds its last value.
- Read latency:
  - ram_rd_x is valid in cycle N+1 and is pushed into FIFO x at the edge ending N+1 (inflight_x flag set at end of N).
  - rsp_valid_x rises in cycle N+2; total latency 2 cycles.
- Credits:
  - occ_x = FIFO count + inflight_x.
  - Read ready_x = (occ_x < RSP_DEPTH) || (rsp_valid_x && rsp_ready_x).
  - Write ready ignores credits; writes generate no response.
  - Full throughput: back-to-back reads with rsp_ready held high, one per cycle.
- Collision (both valid, both we=1, addr_a==addr_b, both otherwise ready):
  - Only the rr_pri port is ready; the other sees ready=0 that cycle.
  - rr_pri toggles after each collision.
- Allowed without stall:
  - Read/write to the same address: the read returns old data (macro read-before-write).
  - Read/read to the same address.
- Response FIFO:
  - Push and pop in the same cycle is permitted.
  - rsp_data is stable while rsp_valid && !rsp_ready.
  - Overflow is impossible by the credit rule; any push to a full FIFO is a design error.
- Reset mid-operation: in-flight reads are discarded; FIFOs flush; the macro array is untouched.

Optional Feature:
- Macro: FAKERAM7_DP_CTRL_CE_GATE_EN.
- Defined: ram_ce=1 only in cycles where at least one port issues (read or write), otherwise 0.
  - The capture path still uses inflight_x, never an ungated ram_rd.
  - rd_out is X in idle cycles and is never sampled.
- Undefined: ram_ce=1 in every cycle after rst_n deasserts (0 during reset).

Test Plan:
- Write then read: A writes addr 0x005, data 0xDEADBEEF, mask 0xFFFFFFFF; A reads 0x005 next cycle -> rsp_valid_a 2 cycles after the read is accepted; rsp_data_a=0xDEADBEEF.
- Masked write: write 0xFFFFFFFF to 0x010; write 0x00000000 with mask 0x0000FFFF; read back -> 0xFFFF0000.
- Write collision: both ports write 0x7FF in the same cycle (A=0x1111_1111, B=0x2222_2222), repeated 3 times.
  - Only one ready per cycle; winners alternate A, B, A.
  - Final read -> value of the last winner.
- Backpressure: 8 back-to-back B reads with rsp_ready_b=0 -> exactly RSP_DEPTH accepted, then req_ready_b=0.
  - Release rsp_ready_b -> all 8 responses arrive in order with correct data and none lost.
- Read/write same address: A reads 0x020 (holding 0xA5A5A5A5) while B writes 0x5A5A5A5A -> A gets 0xA5A5A5A5; a subsequent read gets 0x5A5A5A5A.
- Reset during traffic: assert rst_n low with 2 reads in flight.
  - All outputs at reset values within the same cycle; no rsp_valid after release.
  - ram_ce follows the macro setting for FAKERAM7_DP_CTRL_CE_GATE_EN: idle cycles show ram_ce=0 when defined, 1 when undefined.
